// File: rtl/axis_packet_checker.sv
// axis_packet_checker: AXI-Stream consumer reporting per-packet beat count/sum and sticky protocol errors.
// Define AXIS_CHECKER_SEQ_CHECK_EN to enable the incrementing-data sequence check on err_seq.
module axis_packet_checker #(
    parameter int DATA_SIZE = 32,
    parameter int MAX_BEATS = 16
) (
    input  logic                   s00_axis_aclk,
    input  logic                   s00_axis_areset,
    input  logic                   s00_axis_enable,
    input  logic [DATA_SIZE-1:0]   s00_axis_tdata,
    input  logic [DATA_SIZE/8-1:0] s00_axis_tstrb,
    input  logic                   s00_axis_tvalid,
    input  logic                   s00_axis_tlast,
    output logic                   s00_axis_tready,
    output logic                   pkt_done,
    output logic [7:0]             pkt_beats,
    output logic [DATA_SIZE-1:0]   pkt_sum,
    output logic [15:0]            pkt_count,
    output logic                   err_seq,
    output logic                   err_strb,
    output logic                   err_len
);
    typedef enum logic [1:0] {IDLE, RECV, REPORT} state_t;
    localparam logic [7:0] MAX8 = 8'(MAX_BEATS);
    state_t state, state_n;
    logic [7:0] beats, beats_n;
    logic [DATA_SIZE-1:0] acc, acc_n;
    logic accept, at_max;
    assign accept  = s00_axis_tvalid & s00_axis_tready;
    assign beats_n = beats + 8'd1;
    assign acc_n   = acc + s00_axis_tdata;
    assign at_max  = beats_n == MAX8;
    always_comb begin
        state_n = state;
        if (state == REPORT)
            state_n = IDLE;
        else if (accept)
            state_n = (s00_axis_tlast || at_max) ? REPORT : RECV;
    end
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            state           <= IDLE;
            s00_axis_tready <= 1'b0;
            pkt_done        <= 1'b0;
            pkt_beats       <= '0;
            pkt_sum         <= '0;
            pkt_count       <= '0;
            beats           <= '0;
            acc             <= '0;
            err_strb        <= 1'b0;
            err_len         <= 1'b0;
        end else begin
            state           <= state_n;
            s00_axis_tready <= (state_n != REPORT) & s00_axis_enable;
            pkt_done        <= state_n == REPORT && state != REPORT;
            if (state_n == REPORT && state != REPORT) begin
                pkt_beats <= beats_n;
                pkt_sum   <= acc_n;
                pkt_count <= pkt_count + 16'd1;
            end
            // Counters clear while reporting so IDLE always starts from zero.
            beats <= (state == REPORT) ? '0 : accept ? beats_n : beats;
            acc   <= (state == REPORT) ? '0 : accept ? acc_n : acc;
            if (accept && s00_axis_tstrb != '1)
                err_strb <= 1'b1;
            if (accept && at_max && !s00_axis_tlast)
                err_len <= 1'b1;
        end
    end
`ifdef AXIS_CHECKER_SEQ_CHECK_EN
    logic seq_valid;
    logic [DATA_SIZE-1:0] seq_ref;
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            seq_valid <= 1'b0;
            seq_ref   <= '0;
            err_seq   <= 1'b0;
        end else if (accept) begin
            seq_valid <= 1'b1;
            seq_ref   <= s00_axis_tdata;
            if (seq_valid && s00_axis_tdata != seq_ref + 1'b1)
                err_seq <= 1'b1;
        end
    end
`else
    assign err_seq = 1'b0;
`endif
endmodule

// File: doc/axis_packet_checker.md
AXIS_PACKET_CHECKER -- requirements
Module: axis_packet_checker

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 32, giving the stream data width in bits (multiple of 8).
REQ-002 The block SHALL have parameter MAX_BEATS, default 16, giving the maximum legal packet length in beats (range 1..255).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 The block SHALL have the following ports (name  direction  width  meaning):
- s00_axis_aclk  in  1  sole clock; all logic on the rising edge.
- s00_axis_areset  in  1  asynchronous, active-high reset.
- s00_axis_enable  in  1  when high, the consumer may accept beats.
- s00_axis_tdata  in  DATA_SIZE  stream data from the upstream generator FIFO.
- s00_axis_tstrb  in  DATA_SIZE/8  byte strobes.
- s00_axis_tvalid  in  1  upstream beat valid.
- s00_axis_tlast  in  1  last beat of packet.
- s00_axis_tready  out  1  consumer ready.
- pkt_done  out  1  one-cycle pulse; packet result fields valid.
- pkt_beats  out  8  beat count of the reported packet.
- pkt_sum  out  DATA_SIZE  modulo-2^DATA_SIZE sum of the reported packet's tdata.
- pkt_count  out  16  packets reported since reset; wraps 0xFFFF->0.
- err_seq  out  1  sticky sequence error.
- err_strb  out  1  sticky strobe error.
- err_len  out  1  sticky length error.

Function
REQ-005 A beat SHALL be accepted on a rising edge where s00_axis_tvalid and s00_axis_tready are both high; there is no other way to accept a beat.
REQ-006 The FSM SHALL have three states: IDLE, RECV and REPORT.
REQ-007 s00_axis_tready SHALL be registered and SHALL equal s00_axis_enable in IDLE and RECV; it SHALL be 0 in REPORT.
REQ-008 Transitions:
- IDLE->RECV on an accepted beat without tlast.
- IDLE->REPORT on an accepted beat with tlast (single-beat packet).
- RECV->REPORT on an accepted beat with tlast, or on an accepted beat that makes the beat count equal MAX_BEATS.
- REPORT->IDLE unconditionally after one cycle.
REQ-009 In REPORT the block SHALL pulse pkt_done for exactly one cycle, hold pkt_beats/pkt_sum until the next REPORT, and increment pkt_count.
REQ-010 pkt_sum SHALL accumulate accepted tdata modulo 2^DATA_SIZE; the beat counter and the accumulator SHALL clear on entry to IDLE.
REQ-011 Terminating a packet by reaching MAX_BEATS without tlast SHALL set err_len; any following beats SHALL start a new packet.
REQ-012 An accepted beat whose tstrb is not all ones SHALL set err_strb; the beat is still counted and summed.
REQ-013 Deasserting s00_axis_enable mid-packet SHALL stall acceptance without losing state; the packet resumes when enable returns high.
REQ-014 Error flags SHALL be sticky until reset, and SHALL be set in the cycle after the offending beat.
REQ-015 The total latency from acceptance of the tlast beat to the pkt_done pulse SHALL be 1 cycle.

Reset
REQ-016 While s00_axis_areset is high, regardless of clock, the block SHALL force:
- state IDLE;
- s00_axis_tready, pkt_done, pkt_beats, pkt_sum, pkt_count, err_seq, err_strb and err_len all 0;
- the sequence reference marked invalid.
REQ-017 Reset asserted mid-packet SHALL discard the partial packet with no pkt_done pulse.

Configuration
REQ-018 With macro AXIS_CHECKER_SEQ_CHECK_EN defined, the block SHALL implement the sequence check:
- the first accepted beat after reset only loads the reference;
- every later accepted beat, across packet boundaries, must equal the previous accepted tdata + 1 modulo 2^DATA_SIZE, else err_seq is set.
REQ-019 Without AXIS_CHECKER_SEQ_CHECK_EN, the sequence logic SHALL be absent and err_seq SHALL be tied to 0.

Verification
REQ-020 Bench scenario: reset, enable=1, feed tdata 0..3 with tlast on 3 and tvalid held -> pkt_done one cycle later, pkt_beats=4, pkt_sum=6, pkt_count=1, no errors.
REQ-021 Bench scenario: single beat 0x10 with tlast -> IDLE->REPORT directly, pkt_beats=1, pkt_sum=0x10; tready is 0 during REPORT.
REQ-022 Bench scenario: 16 beats with no tlast (MAX_BEATS=16) -> pkt_done with pkt_beats=16 and err_len=1; beat 17 starts a new packet.
REQ-023 Bench scenario: tstrb=0x7 on beat 2 -> err_strb=1 and stays 1; the beat is still counted.
REQ-024 Bench scenario, with AXIS_CHECKER_SEQ_CHECK_EN: tdata 5,6,8 -> err_seq=1 after beat 8. Without the macro, the same stimulus -> err_seq=0.
REQ-025 Bench scenario: drop enable for 5 cycles mid-packet, then assert reset mid-packet -> no beats accepted while stalled; after reset all outputs are 0 and there is no pkt_done pulse.
